// File: rtl/karatsuba_pkg.sv
// karatsuba_pkg: shared product width and accumulator FSM encoding for the Karatsuba blocks
package karatsuba_pkg;
    localparam int PW = 64;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/karatsuba_mac_acc_if.sv
// karatsuba_mac_acc_if: product stream in, accumulated result out with valid/ready handshake
interface karatsuba_mac_acc_if import karatsuba_pkg::*; #(
    parameter int AW = 72,
    parameter int LW = 8
) ();
    logic          start;
    logic [LW-1:0] len;
    logic          prod_valid;
    logic [PW-1:0] prod;
    logic          busy;
    logic          res_valid;
    logic          res_ready;
    logic [AW-1:0] res;
    logic          ovf;
    logic          drop;
    modport master (
        output start, len, prod_valid, prod, res_ready,
        input  busy, res_valid, res, ovf, drop
    );
    modport slave (
        input  start, len, prod_valid, prod, res_ready,
        output busy, res_valid, res, ovf, drop
    );
endinterface

// File: rtl/karatsuba_acc_add.sv
// karatsuba_acc_add: AW-bit accumulate adder with carry out; isolated so it can be retimed later
module karatsuba_acc_add import karatsuba_pkg::*; #(
    parameter int AW = 72
) (
    input  logic [AW-1:0] acc,
    input  logic [PW-1:0] prod,
    output logic [AW-1:0] sum,
    output logic          carry
);
    assign {carry, sum} = {1'b0, acc} + {1'b0, AW'(prod)};
endmodule

// File: rtl/karatsuba_mac_acc.sv
// karatsuba_mac_acc: accumulates a run of len products and presents the sum via valid/ready
module karatsuba_mac_acc import karatsuba_pkg::*; #(
    parameter int AW = 72,
    parameter int LW = 8
) (
    input logic                clk,
    input logic                rst,
    karatsuba_mac_acc_if.slave bus
);
    state_t        state_q, state_d;
    logic [AW-1:0] acc_q, acc_d, sum;
    logic [LW-1:0] cnt_q, cnt_d, len_q, len_d;
    logic          ovf_q, ovf_d, drop_q, drop_d, busy_q, busy_d, res_valid_q, res_valid_d;
    logic          carry, take_start;

    karatsuba_acc_add #(.AW(AW)) u_add (
        .acc  (acc_q),
        .prod (bus.prod),
        .sum  (sum),
        .carry(carry)
    );

    always_comb begin
        take_start  = bus.start & ((state_q == IDLE) | ((state_q == DONE) & bus.res_ready));
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        ovf_d       = ovf_q;
        drop_d      = drop_q | (bus.prod_valid & (state_q != ACC));
        if (state_q == ACC) begin
            if (bus.prod_valid) begin
                acc_d   = sum;
                ovf_d   = ovf_q | carry;
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == len_q - 1'b1) ? DONE : ACC;
            end
        end else if (take_start) begin
            state_d = (bus.len == '0) ? DONE : ACC;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            len_d   = bus.len;
        end else if ((state_q == DONE) & bus.res_ready) begin
            state_d = IDLE;
        end
        busy_d      = state_d != IDLE;
        res_valid_d = state_d == DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            ovf_q       <= 1'b0;
            drop_q      <= 1'b0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            ovf_q       <= ovf_d;
            drop_q      <= drop_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res       = acc_q;
    assign bus.ovf       = ovf_q;
    assign bus.drop      = drop_q;
endmodule
